// File: rtl/wb_pio_initiator.sv
// -----------------------------------------------------------------------------
// wb_pio_initiator
//
// Converts single programmed-I/O commands into Wishbone classic bus cycles and
// returns one response per command. A transfer that is not acknowledged within
// TIMEOUT bus cycles is aborted and reported with rsp_err_o.
//
// Parameters
//   TIMEOUT       bus cycles allowed before an unacknowledged transfer aborts
//                 (legal 2..255)
//
// Ports
//   wb_clk_i      clock, all logic on the rising edge
//   wb_rst_ni     synchronous active-low reset
//   cmd_valid_i   command request
//   cmd_ready_o   command accepted when high together with cmd_valid_i
//   cmd_we_i      1 = write, 0 = read
//   cmd_adr_i     byte address
//   cmd_dat_i     write data
//   cmd_sel_i     byte lanes
//   rsp_valid_o   response available
//   rsp_ready_i   response consumed
//   rsp_dat_o     read data (0 for writes and timeouts)
//   rsp_err_o     1 = transfer timed out
//   wbm_cyc_o     Wishbone cycle
//   wbm_stb_o     Wishbone strobe
//   wbm_we_o      Wishbone write enable
//   wbm_sel_o     Wishbone byte selects
//   wbm_adr_o     Wishbone address
//   wbm_dat_o     Wishbone write data (0 during reads)
//   wbm_ack_i     Wishbone acknowledge
//   wbm_dat_i     Wishbone read data
//
// State table
//   state   | meaning
//   IDLE    | waiting for a command, cmd_ready_o high
//   BUS     | cycle presented on Wishbone, waiting for ack or timeout
//   RESP    | response held until rsp_ready_i
// -----------------------------------------------------------------------------
module wb_pio_initiator #(
    parameter int TIMEOUT = 64
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,

    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic [3:0]  cmd_sel_i,

    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,

    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic        wbm_ack_i,
    input  logic [31:0] wbm_dat_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Timer value seen during the last permitted bus cycle.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,     state_d;
    logic [7:0]  timer_q,     timer_d;
    logic        cyc_q,       cyc_d;
    logic        we_q,        we_d;
    logic [3:0]  sel_q,       sel_d;
    logic [31:0] adr_q,       adr_d;
    logic [31:0] dat_q,       dat_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        rsp_err_q,   rsp_err_d;
    logic [31:0] rsp_dat_q,   rsp_dat_d;

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_ni) begin
            state_q     <= ST_IDLE;
            timer_q     <= 8'd0;
            cyc_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= 4'd0;
            adr_q       <= 32'd0;
            dat_q       <= 32'd0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= 32'd0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            cyc_q       <= cyc_d;
            we_q        <= we_d;
            sel_q       <= sel_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        cyc_d       = cyc_q;
        we_d        = we_q;
        sel_d       = sel_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_err_d   = rsp_err_q;
        rsp_dat_d   = rsp_dat_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i) begin
                    state_d = ST_BUS;
                    timer_d = 8'd0;
                    cyc_d   = 1'b1;
                    we_d    = cmd_we_i;
                    sel_d   = cmd_sel_i;
                    adr_d   = cmd_adr_i;
                    // Reads never drive data onto the bus.
                    dat_d   = cmd_we_i ? cmd_dat_i : 32'd0;
                end
            end

            ST_BUS: begin
                // Ack takes priority over a timeout expiring in the same cycle.
                if (wbm_ack_i) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_dat_d   = we_q ? 32'd0 : wbm_dat_i;
                end else if (timer_q == TIMER_LAST) begin
                    state_d     = ST_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_dat_d   = 32'd0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end

                // Leaving the bus: release the cycle and quiet the lines.
                if (wbm_ack_i || timer_q == TIMER_LAST) begin
                    cyc_d = 1'b0;
                    we_d  = 1'b0;
                    sel_d = 4'd0;
                    adr_d = 32'd0;
                    dat_d = 32'd0;
                end
            end

            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    assign cmd_ready_o = (state_q == ST_IDLE);

    assign wbm_cyc_o   = cyc_q;
    assign wbm_stb_o   = cyc_q;
    assign wbm_we_o    = we_q;
    assign wbm_sel_o   = sel_q;
    assign wbm_adr_o   = adr_q;
    assign wbm_dat_o   = dat_q;

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_err_o   = rsp_err_q;
    assign rsp_dat_o   = rsp_dat_q;

endmodule
